hcsr04_ranger: RTL and testbench



---
 rtl/pong_sensor_pkg.sv | 23 ++
 rtl/sync_edge.sv | 27 ++
 rtl/hcsr04_ranger.sv | 156 +++++++++++++++
 tb/tb_hcsr04_ranger.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_sensor_pkg.sv
// Shared definitions for the pong ultrasonic paddle sensors and game logic.
package pong_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } sensor_state_t;

  localparam int unsigned DMIN_DEFAULT     = 5;
  localparam int unsigned DMAX_DEFAULT     = 40;
  localparam int unsigned Y_PER_CM_DEFAULT = 19;
  localparam int unsigned Y_MAX_DEFAULT    = 668;

  // Clock cycles in a span of microseconds, whole MHz assumed.
  function automatic int unsigned cycles_from_us(input longint unsigned clk_hz,
                                                 input longint unsigned us);
    return 32'(clk_hz / 64'd1_000_000 * us);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with single-cycle rise and fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 front end: periodic trigger, echo width to centimetres and clamped paddle Y.
module hcsr04_ranger
  import pong_sensor_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 65_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_MS  = 60,
  parameter int unsigned RISE_TO_US = 2000,
  parameter int unsigned DIST_MAX   = 400,
  parameter int unsigned DMIN       = DMIN_DEFAULT,
  parameter int unsigned DMAX       = DMAX_DEFAULT,
  parameter int unsigned Y_PER_CM   = Y_PER_CM_DEFAULT,
  parameter int unsigned Y_MAX      = Y_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] dist_cm,
  output logic [9:0] paddle_y,
  output logic       dist_valid,
  output logic       no_echo
);

  localparam int unsigned TRIG_CYC   = cycles_from_us(64'(CLK_HZ), 64'(TRIG_US));
  localparam int unsigned RISE_CYC   = cycles_from_us(64'(CLK_HZ), 64'(RISE_TO_US));
  localparam int unsigned PERIOD_CYC = 32'(64'(CLK_HZ) / 64'd1000 * 64'(PERIOD_MS));
  localparam int unsigned CYC_PER_CM = 32'(64'(CLK_HZ) * 64'd58 / 64'd1_000_000);
  localparam int unsigned PER_W      = $clog2(PERIOD_CYC);
  localparam int unsigned SUB_MAX    = (RISE_CYC > CYC_PER_CM) ? RISE_CYC : CYC_PER_CM;
  localparam int unsigned SUB_W      = $clog2(SUB_MAX + 1);

  sensor_state_t    state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [8:0]       cm_acc_q, cm_acc_d;
  logic [8:0]       dist_q, dist_d;
  logic [9:0]       paddle_q, paddle_d;
  logic             trig_q, trig_d;
  logic             valid_q, valid_d;
  logic             no_echo_q, no_echo_d;
  logic             echo_rise, echo_fall;
  logic [15:0]      d_clamp, y_prod;
  logic [9:0]       y_map;

  sync_edge u_echo_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (echo),
    .rise (echo_rise),
    .fall (echo_fall)
  );

  // Clamp before multiplying; truncate to 10 bits only after the Y_MAX limit.
  always_comb begin
    d_clamp = 16'(cm_acc_q);
    if (d_clamp < 16'(DMIN)) d_clamp = 16'(DMIN);
    if (d_clamp > 16'(DMAX)) d_clamp = 16'(DMAX);
    y_prod = (d_clamp - 16'(DMIN)) * 16'(Y_PER_CM);
    y_map  = (y_prod > 16'(Y_MAX)) ? 10'(Y_MAX) : y_prod[9:0];
  end

  always_comb begin
    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    cm_acc_d  = cm_acc_q;
    dist_d    = dist_q;
    paddle_d  = paddle_q;
    valid_d   = 1'b0;
    no_echo_d = 1'b0;
    per_cnt_d = (per_cnt_q == PER_W'(PERIOD_CYC - 1)) ? '0 : per_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (per_cnt_q == PER_W'(PERIOD_CYC - 1)) begin
          state_d   = TRIG;
          per_cnt_d = '0;
        end
      end
      // The period counter restarts on TRIG entry, so it also times the pulse.
      TRIG: begin
        if (per_cnt_q == PER_W'(TRIG_CYC - 1)) begin
          state_d   = WAIT_RISE;
          sub_cnt_d = '0;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d   = MEASURE;
          sub_cnt_d = '0;
          cm_acc_d  = '0;
        end else if (sub_cnt_q == SUB_W'(RISE_CYC - 1)) begin
          state_d   = IDLE;
          no_echo_d = 1'b1;
        end else begin
          sub_cnt_d = sub_cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        // Stuck-high echo: give up in time for the next trigger to stay on grid.
        if (per_cnt_q == PER_W'(PERIOD_CYC - 2)) begin
          state_d   = IDLE;
          no_echo_d = 1'b1;
        end else begin
          if (sub_cnt_q == SUB_W'(CYC_PER_CM - 1)) begin
            sub_cnt_d = '0;
            if (cm_acc_q < 9'(DIST_MAX)) cm_acc_d = cm_acc_q + 1'b1;
          end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
          end
          if (echo_fall) state_d = DONE;
        end
      end
      DONE: begin
        dist_d   = cm_acc_q;
        paddle_d = y_map;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    trig_d = (state_d == TRIG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      sub_cnt_q <= '0;
      cm_acc_q  <= '0;
      dist_q    <= '0;
      paddle_q  <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      no_echo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      cm_acc_q  <= cm_acc_d;
      dist_q    <= dist_d;
      paddle_q  <= paddle_d;
      trig_q    <= trig_d;
      valid_q   <= valid_d;
      no_echo_q <= no_echo_d;
    end
  end

  assign trig       = trig_q;
  assign dist_cm    = dist_q;
  assign paddle_y   = paddle_q;
  assign dist_valid = valid_q;
  assign no_echo    = no_echo_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger: short-period instances plus one full-period instance.
module tb_hcsr04_ranger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_a = 1'b1;
  logic       echo = 1'b0;
  logic       echo_a = 1'b0;

  logic       trig, dist_valid, no_echo;
  logic [8:0] dist_cm;
  logic [9:0] paddle_y;
  logic       trig_c, dist_valid_c, no_echo_c;
  logic [8:0] dist_cm_c;
  logic [9:0] paddle_y_c;
  logic       trig_a, dist_valid_a, no_echo_a;
  logic [8:0] dist_cm_a;
  logic [9:0] paddle_y_a;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned last_rise = 0;
  int unsigned rel_cyc = 0;
  int unsigned a_rise = 0;
  int unsigned a_width = 0;
  int unsigned a_early = 0;
  int unsigned both_hi = 0;

  // 5000-cycle period instance (main), same with Y_PER_CM=30, and the 60000-cycle default period.
  hcsr04_ranger #(.CLK_HZ(1_000_000), .PERIOD_MS(5)) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .dist_cm(dist_cm),
    .paddle_y(paddle_y), .dist_valid(dist_valid), .no_echo(no_echo)
  );

  hcsr04_ranger #(.CLK_HZ(1_000_000), .PERIOD_MS(5), .Y_PER_CM(30)) dut_c (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig_c), .dist_cm(dist_cm_c),
    .paddle_y(paddle_y_c), .dist_valid(dist_valid_c), .no_echo(no_echo_c)
  );

  hcsr04_ranger #(.CLK_HZ(1_000_000), .PERIOD_MS(60)) dut_a (
    .clk(clk), .rst(rst_a), .echo(echo_a), .trig(trig_a), .dist_cm(dist_cm_a),
    .paddle_y(paddle_y_a), .dist_valid(dist_valid_a), .no_echo(no_echo_a)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig_a && a_rise == 0) a_rise <= cyc;
    if (trig_a) a_width <= a_width + 1;
    if (!rst_a && cyc < rel_cyc + 60000 &&
        (trig_a || dist_cm_a != 0 || paddle_y_a != 0 || dist_valid_a || no_echo_a))
      a_early <= a_early + 1;
    if (dist_valid && no_echo) both_hi <= both_hi + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the next trigger, checks the period grid and pulse width; returns after the fall.
  task automatic next_trig();
    int n;
    n = 0;
    while (trig !== 1'b1 && n < 6000) begin
      tick(1);
      n++;
    end
    check("trig_period", cyc - last_rise, 5000);
    last_rise = cyc;
    n = 0;
    while (trig === 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("trig_width", n, 10);
  endtask

  task automatic measure(input int width, input int exp_cm, input int exp_y, input int exp_yc);
    int n;
    tick(300);
    echo = 1'b1;
    tick(width);
    echo = 1'b0;
    n = 0;
    while (dist_valid !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check("valid_latency", n, 4);
    check("dist_cm", 32'(dist_cm), exp_cm);
    check("paddle_y", 32'(paddle_y), exp_y);
    check("paddle_y_c", 32'(paddle_y_c), exp_yc);
    check("valid_c", 32'(dist_valid_c), 1);
    check("no_echo_at_valid", 32'(no_echo), 0);
    tick(1);
    check("valid_one_cycle", 32'(dist_valid), 0);
  endtask

  initial begin
    int n;
    tick(3);
    check("rst_trig", 32'(trig), 0);
    check("rst_dist", 32'(dist_cm), 0);
    check("rst_paddle", 32'(paddle_y), 0);
    check("rst_valid", 32'(dist_valid), 0);
    check("rst_no_echo", 32'(no_echo), 0);
    rst = 1'b0;
    rst_a = 1'b0;
    last_rise = cyc;
    rel_cyc = cyc;
    tick(4999);
    check("pre_trig_low", 32'(trig), 0);
    check("pre_trig_dist", 32'(dist_cm), 0);
    next_trig();
    measure(174, 3, 0, 0);
    next_trig();
    measure(3480, 60, 665, 668);
    next_trig();
    measure(2320, 40, 665, 668);
    next_trig();
    measure(1160, 20, 285, 450);

    // No echo at all.
    next_trig();
    n = 0;
    while (no_echo !== 1'b1 && n < 2100) begin
      tick(1);
      n++;
    end
    check("no_echo_delay", n, 2000);
    check("no_echo_valid_low", 32'(dist_valid), 0);
    check("no_echo_dist_hold", 32'(dist_cm), 20);
    check("no_echo_paddle_hold", 32'(paddle_y), 285);
    tick(1);
    check("no_echo_one_cycle", 32'(no_echo), 0);

    // Echo rises and never falls.
    next_trig();
    tick(300);
    echo = 1'b1;
    n = 0;
    while (no_echo !== 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    check("stuck_timeout", n, 4689);
    check("stuck_dist_hold", 32'(dist_cm), 20);
    check("stuck_paddle_hold", 32'(paddle_y), 285);

    // Echo already high when WAIT_RISE is entered.
    next_trig();
    n = 0;
    while (no_echo !== 1'b1 && n < 2100) begin
      tick(1);
      n++;
    end
    check("high_at_entry_timeout", n, 2000);
    check("high_at_entry_dist", 32'(dist_cm), 20);

    // Reset in the middle of a measurement.
    echo = 1'b0;
    next_trig();
    tick(300);
    echo = 1'b1;
    tick(500);
    rst = 1'b1;
    #1;
    check("midrst_trig", 32'(trig), 0);
    check("midrst_dist", 32'(dist_cm), 0);
    check("midrst_paddle", 32'(paddle_y), 0);
    check("midrst_valid", 32'(dist_valid), 0);
    check("midrst_no_echo", 32'(no_echo), 0);
    echo = 1'b0;
    tick(3);
    rst = 1'b0;
    last_rise = cyc;
    next_trig();
    measure(1160, 20, 285, 450);

    // Full-length default-period instance.
    while (cyc < rel_cyc + 60020) tick(1);
    check("full_first_trig", a_rise - rel_cyc, 60000);
    check("full_trig_width", a_width, 10);
    check("full_early_outputs", a_early, 0);
    check("valid_and_no_echo", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
